// File: rtl/ofs_fim_eth_pkt_gen_pkg.sv
// Shared types and helpers for the Ethernet AVST TX packet generator.
// Holds the FSM state encoding, default data width and length arithmetic.
package ofs_fim_eth_pkt_gen_pkg;

    localparam int DEFAULT_DATA_W = 64;
    localparam int LEN_W          = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } pkt_gen_state_e;

    // Unused upper byte lanes on the final beat of a packet of len bytes.
    function automatic int unsigned calc_empty(input logic [LEN_W-1:0] len,
                                               input int unsigned      bytes_per_beat);
        int unsigned rem;
        rem = 32'(len) % bytes_per_beat;
        return (rem == 32'd0) ? 32'd0 : (bytes_per_beat - rem);
    endfunction

    function automatic int unsigned calc_beats(input logic [LEN_W-1:0] len,
                                               input int unsigned      bytes_per_beat);
        return (32'(len) + bytes_per_beat - 32'd1) / bytes_per_beat;
    endfunction

endpackage

// File: rtl/ofs_fim_eth_pkt_gen_pattern.sv
// Combinational payload generator: byte at offset i is seq + i, lanes past
// the end of the packet are zeroed.
module ofs_fim_eth_pkt_gen_pattern
    import ofs_fim_eth_pkt_gen_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic [7:0]        i_seq,
    input  logic [LEN_W-1:0]  i_beat,
    input  logic [LEN_W-1:0]  i_len,
    output logic [DATA_W-1:0] o_data
);

    localparam int BPB = DATA_W / 8;

    logic [31:0] w_base;

    assign w_base = 32'(i_beat) * 32'(BPB);

    // Per-lane byte value derived from the absolute byte offset in the packet.
    always_comb begin
        o_data = '0;
        for (int lane = 0; lane < BPB; lane++) begin
            if ((w_base + 32'(lane)) < 32'(i_len)) begin
                o_data[lane*8 +: 8] = i_seq + w_base[7:0] + 8'(lane);
            end else begin
                o_data[lane*8 +: 8] = 8'd0;
            end
        end
    end

endmodule

// File: rtl/ofs_fim_eth_avst_tx_pkt_gen.sv
// AVST TX packet generator: emits runs of fixed-length incrementing-pattern
// packets with a programmable inter-packet gap, honouring sink backpressure.
module ofs_fim_eth_avst_tx_pkt_gen
    import ofs_fim_eth_pkt_gen_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int EMPTY_W = $clog2(DATA_W/8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [13:0]        pkt_len,
    input  logic [15:0]        pkt_count,
    input  logic [7:0]         ipg_cycles,
    input  logic               tx_ready,
    output logic               tx_valid,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_sop,
    output logic               tx_eop,
    output logic [EMPTY_W-1:0] tx_empty,
    output logic               tx_error,
    output logic               busy,
    output logic               done,
    output logic [31:0]        pkt_sent_cnt
);

    localparam int BPB = DATA_W / 8;

    pkt_gen_state_e     r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_last_beat;
    logic [LEN_W-1:0]   r_beat;
    logic [15:0]        r_count;
    logic [7:0]         r_ipg;
    logic [7:0]         r_gap;
    logic [15:0]        r_seq;
    logic               r_stop_pend;
    logic [31:0]        r_sent;
    logic               r_valid;
    logic               r_sop;
    logic               r_eop;
    logic [EMPTY_W-1:0] r_empty;
    logic [DATA_W-1:0]  r_data;
    logic               r_done;
    logic               r_busy;

    pkt_gen_state_e     w_state_nxt;
    logic               w_accept;
    logic               w_load;
    logic               w_clr_valid;
    logic               w_done;
    logic [15:0]        w_ld_seq;
    logic [LEN_W-1:0]   w_ld_beat;
    logic [LEN_W-1:0]   w_ld_len;
    logic [LEN_W-1:0]   w_ld_last;
    logic               w_ld_eop;
    logic [EMPTY_W-1:0] w_ld_empty;
    logic [DATA_W-1:0]  w_pat_data;
    logic [7:0]         w_gap_nxt;
    logic [LEN_W-1:0]   w_start_last;
    logic               w_xfer;
    logic               w_eop_xfer;
    logic               w_last_pkt;
    logic               w_stop_any;
    logic [31:0]        w_sent_inc;

    assign w_xfer       = r_valid & tx_ready;
    assign w_eop_xfer   = w_xfer & r_eop;
    assign w_stop_any   = stop | r_stop_pend;
    assign w_sent_inc   = (r_sent == 32'hFFFF_FFFF) ? r_sent : (r_sent + 32'd1);
    assign w_last_pkt   = (r_count != 16'd0) && ((r_sent + 32'd1) == {16'd0, r_count});
    assign w_start_last = LEN_W'(calc_beats(pkt_len, BPB) - 32'd1);
    assign w_ld_eop     = (w_ld_beat == w_ld_last);
    assign w_ld_empty   = w_ld_eop ? EMPTY_W'(calc_empty(w_ld_len, BPB)) : '0;

    ofs_fim_eth_pkt_gen_pattern #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .i_seq  (w_ld_seq[7:0]),
        .i_beat (w_ld_beat),
        .i_len  (w_ld_len),
        .o_data (w_pat_data)
    );

    // Next-state logic; w_load selects the beat presented in the next cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_clr_valid = 1'b0;
        w_done      = 1'b0;
        w_ld_seq    = r_seq;
        w_ld_beat   = r_beat;
        w_ld_len    = r_len;
        w_ld_last   = r_last_beat;
        w_gap_nxt   = r_gap;
        case (r_state)
            ST_IDLE: begin
                if (start && (pkt_len != 14'd0)) begin
                    w_state_nxt = ST_SEND;
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_ld_seq    = 16'd0;
                    w_ld_beat   = '0;
                    w_ld_len    = pkt_len;
                    w_ld_last   = w_start_last;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (w_eop_xfer) begin
                    if (w_last_pkt || w_stop_any) begin
                        w_state_nxt = ST_IDLE;
                        w_clr_valid = 1'b1;
                        w_done      = 1'b1;
                    end else if (r_ipg == 8'd0) begin
                        w_load    = 1'b1;
                        w_ld_seq  = r_seq + 16'd1;
                        w_ld_beat = '0;
                    end else begin
                        w_state_nxt = ST_GAP;
                        w_clr_valid = 1'b1;
                        w_gap_nxt   = r_ipg;
                    end
                end else if (w_xfer) begin
                    w_load    = 1'b1;
                    w_ld_beat = r_beat + LEN_W'(1);
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_GAP: begin
                // seq was already advanced by the eop transfer that opened the gap
                if (w_stop_any) begin
                    w_state_nxt = ST_IDLE;
                    w_done      = 1'b1;
                end else if (r_gap <= 8'd1) begin
                    w_state_nxt = ST_SEND;
                    w_load      = 1'b1;
                    w_ld_beat   = '0;
                end else begin
                    w_gap_nxt = r_gap - 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_clr_valid = 1'b1;
            end
        endcase
    end

    // Control state: FSM, run configuration, sequence, counters and pending stop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_last_beat <= '0;
            r_count     <= 16'd0;
            r_ipg       <= 8'd0;
            r_gap       <= 8'd0;
            r_seq       <= 16'd0;
            r_stop_pend <= 1'b0;
            r_sent      <= 32'd0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done;
            r_gap   <= w_gap_nxt;
            if (w_accept) begin
                r_len       <= pkt_len;
                r_last_beat <= w_start_last;
                r_count     <= pkt_count;
                r_ipg       <= ipg_cycles;
                r_seq       <= 16'd0;
                r_sent      <= 32'd0;
            end else if (w_eop_xfer) begin
                r_seq  <= r_seq + 16'd1;
                r_sent <= w_sent_inc;
            end else begin
                r_seq  <= r_seq;
                r_sent <= r_sent;
            end
            if (w_state_nxt == ST_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (stop && (r_state != ST_IDLE)) begin
                r_stop_pend <= 1'b1;
            end else begin
                r_stop_pend <= r_stop_pend;
            end
        end
    end

    // Output beat registers; they only change on a load or a clear, so a stall holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
            r_data  <= '0;
            r_beat  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_sop   <= (w_ld_beat == '0);
            r_eop   <= w_ld_eop;
            r_empty <= w_ld_empty;
            r_data  <= w_pat_data;
            r_beat  <= w_ld_beat;
        end else if (w_clr_valid) begin
            r_valid <= 1'b0;
            r_sop   <= 1'b0;
            r_eop   <= 1'b0;
            r_empty <= '0;
            r_data  <= '0;
            r_beat  <= '0;
        end else begin
            r_valid <= r_valid;
        end
    end

    assign tx_valid     = r_valid;
    assign tx_data      = r_data;
    assign tx_sop       = r_sop;
    assign tx_eop       = r_eop;
    assign tx_empty     = r_empty;
    assign tx_error     = 1'b0;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pkt_sent_cnt = r_sent;

endmodule

// File: tb/tb_ofs_fim_eth_avst_tx_pkt_gen.sv
// Self-checking bench for the AVST TX packet generator with a packet-level
// reference model and randomized sink backpressure.
module tb_ofs_fim_eth_avst_tx_pkt_gen;

    localparam int DATA_W  = 64;
    localparam int EMPTY_W = 3;
    localparam int BPB     = 8;

    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [DATA_W-1:0]  data;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst, start, stop, tx_ready;
    logic [13:0]        pkt_len;
    logic [15:0]        pkt_count;
    logic [7:0]         ipg_cycles;
    logic               tx_valid, tx_sop, tx_eop, tx_error, busy, done;
    logic [DATA_W-1:0]  tx_data;
    logic [EMPTY_W-1:0] tx_empty;
    logic [31:0]        pkt_sent_cnt;

    beat_t obs_q[$];
    beat_t exp_q[$];
    int    gap_q[$];
    int    n_done = 0;
    int    stall_err = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    ready_mode = 0;
    int    ready_phase = 0;

    always #5 clk = ~clk;

    ofs_fim_eth_avst_tx_pkt_gen dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .pkt_len(pkt_len), .pkt_count(pkt_count), .ipg_cycles(ipg_cycles),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty),
        .tx_error(tx_error), .busy(busy), .done(done), .pkt_sent_cnt(pkt_sent_cnt)
    );

    // Observes transfers, stall stability, gap lengths and done pulses.
    initial begin : monitor
        beat_t prev;
        logic  prev_stall;
        logic  in_gap;
        int    gcnt;
        prev = '0; prev_stall = 1'b0; in_gap = 1'b0; gcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                in_gap     = 1'b0;
            end else begin
                if (prev_stall && (tx_valid !== 1'b1 || {tx_sop, tx_eop, tx_empty, tx_data} !== prev))
                    stall_err++;
                if (in_gap && tx_valid) begin
                    gap_q.push_back(gcnt);
                    in_gap = 1'b0;
                end else if (in_gap) begin
                    gcnt++;
                end
                if (tx_valid && tx_ready) begin
                    obs_q.push_back({tx_sop, tx_eop, tx_empty, tx_data});
                    if (tx_eop) begin
                        in_gap = 1'b1;
                        gcnt   = 0;
                    end
                end
                if (done === 1'b1) begin
                    n_done++;
                    in_gap = 1'b0;
                end
                prev_stall = tx_valid && !tx_ready;
                prev       = {tx_sop, tx_eop, tx_empty, tx_data};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ($urandom_range(0, 3) != 0);
            2: begin
                tx_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
                ready_phase++;
            end
            default: tx_ready = 1'b1;
        endcase
    endtask

    task automatic start_run(input int len, input int cnt, input int ipg);
        step();
        pkt_len = 14'(len); pkt_count = 16'(cnt); ipg_cycles = 8'(ipg);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int d0;
        int k;
        d0 = n_done; k = 0;
        while (n_done == d0 && k < budget) begin
            step();
            k++;
        end
        ok = (n_done != d0);
        repeat (3) step();
    endtask

    // Reference: every packet of a run, byte i of packet p is (p + i) mod 256.
    task automatic build_exp(input int len, input int npkts);
        beat_t bt;
        int    nb;
        exp_q.delete();
        nb = (len + BPB - 1) / BPB;
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < nb; b++) begin
                bt     = '0;
                bt.sop = (b == 0);
                bt.eop = (b == nb - 1);
                if (b == nb - 1) bt.empty = EMPTY_W'((BPB - len % BPB) % BPB);
                for (int l = 0; l < BPB; l++)
                    if (b * BPB + l < len) bt.data[l*8 +: 8] = 8'((p + b * BPB + l) % 256);
                exp_q.push_back(bt);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0; tx_ready = 1'b1;
        pkt_len = 14'd0; pkt_count = 16'd0; ipg_cycles = 8'd0;
        repeat (3) step();
        n_chk++;
        if ({tx_valid, tx_sop, tx_eop, busy, done, tx_error} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 000000", {tx_valid, tx_sop, tx_eop, busy, done, tx_error});
        end
        n_chk++;
        if (tx_data !== 64'd0 || tx_empty !== 3'd0) begin
            n_fail++; $display("FAIL reset_data got %h/%0d exp 0/0", tx_data, tx_empty);
        end
        n_chk++;
        if (pkt_sent_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_cnt got %0d exp 0", pkt_sent_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        int base; int gb; int d0; bit ok;
        ready_mode = 0; base = obs_q.size(); gb = gap_q.size(); d0 = n_done;
        build_exp(64, 3);
        start_run(64, 3, 0);
        n_chk++;
        if (tx_valid !== 1'b1 || tx_sop !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_latency got v=%b s=%b b=%b exp 1 1 1", tx_valid, tx_sop, busy);
        end
        wait_done(300, ok);
        n_chk++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout got no done exp done"); end
        n_chk++;
        if (obs_q.size() - base !== 24) begin
            n_fail++; $display("FAIL b2b_nbeats got %0d exp 24", obs_q.size() - base);
        end
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            n_chk++;
            if (obs_q[base+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_beat%0d got %h exp %h", i, obs_q[base+i], exp_q[i]);
            end
        end
        n_chk++;
        if (gap_q.size() - gb !== 2 || gap_q[gb] !== 0 || gap_q[gb+1] !== 0) begin
            n_fail++; $display("FAIL b2b_contig got %0d gaps exp 2 zero gaps", gap_q.size() - gb);
        end
        n_chk++;
        if (n_done - d0 !== 1 || pkt_sent_cnt !== 32'd3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got done=%0d cnt=%0d busy=%b exp 1 3 0", n_done - d0, pkt_sent_cnt, busy);
        end
    endtask

    task automatic test_short_eop();
        int base; bit ok;
        ready_mode = 0; base = obs_q.size();
        build_exp(61, 1);
        start_run(61, 1, 0);
        wait_done(100, ok);
        n_chk++;
        if (!ok || obs_q.size() - base !== 8) begin
            n_fail++; $display("FAIL short_nbeats got %0d ok=%b exp 8", obs_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_chk++;
                if (obs_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL short_beat%0d got %h exp %h", i, obs_q[base+i], exp_q[i]);
                end
            end
            n_chk++;
            if (obs_q[base+7].empty !== 3'd3 || obs_q[base+7].data[63:40] !== 24'd0 || obs_q[base+7].data[39:32] !== 8'h3C) begin
                n_fail++; $display("FAIL short_eop got %h exp empty 3 byte60 3c upper 0", obs_q[base+7]);
            end
        end
    endtask

    task automatic test_backpressure();
        int base; int s0; bit ok;
        ready_mode = 2; ready_phase = 0; base = obs_q.size(); s0 = stall_err;
        build_exp(100, 1);
        start_run(100, 1, 0);
        wait_done(200, ok);
        n_chk++;
        if (!ok || obs_q.size() - base !== 13) begin
            n_fail++; $display("FAIL bp_nbeats got %0d ok=%b exp 13", obs_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 13; i++) begin
                n_chk++;
                if (obs_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL bp_beat%0d got %h exp %h", i, obs_q[base+i], exp_q[i]);
                end
            end
            n_chk++;
            if (obs_q[base+12].empty !== 3'd4) begin
                n_fail++; $display("FAIL bp_empty got %0d exp 4", obs_q[base+12].empty);
            end
        end
        n_chk++;
        if (stall_err - s0 !== 0) begin
            n_fail++; $display("FAIL bp_stable got %0d unstable stalls exp 0", stall_err - s0);
        end
    endtask

    task automatic test_gap();
        int base; int gb; bit ok;
        ready_mode = 0; base = obs_q.size(); gb = gap_q.size();
        build_exp(40, 2);
        start_run(40, 2, 5);
        wait_done(200, ok);
        n_chk++;
        if (!ok || gap_q.size() - gb !== 1 || gap_q[gb] !== 5) begin
            n_fail++; $display("FAIL gap_len got n=%0d ok=%b exp one gap of 5", gap_q.size() - gb, ok);
        end
        n_chk++;
        if (obs_q.size() - base !== 10) begin
            n_fail++; $display("FAIL gap_nbeats got %0d exp 10", obs_q.size() - base);
        end else begin
            n_chk++;
            if (obs_q[base+5].data[7:0] !== 8'h01 || obs_q[base+5] !== exp_q[5]) begin
                n_fail++; $display("FAIL gap_seq got %h exp %h", obs_q[base+5], exp_q[5]);
            end
        end
    endtask

    task automatic test_stop_continuous();
        int base; int d0; int k; bit ok;
        ready_mode = 1; base = obs_q.size(); d0 = n_done;
        build_exp(32, 4);
        start_run(32, 0, 2);
        k = 0;
        while (obs_q.size() - base < 13 && k < 500) begin step(); k++; end
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_done(300, ok);
        n_chk++;
        if (!ok || obs_q.size() - base !== 16) begin
            n_fail++; $display("FAIL stop_nbeats got %0d ok=%b exp 16", obs_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_chk++;
                if (obs_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL stop_beat%0d got %h exp %h", i, obs_q[base+i], exp_q[i]);
                end
            end
        end
        n_chk++;
        if (n_done - d0 !== 1 || pkt_sent_cnt !== 32'd4) begin
            n_fail++; $display("FAIL stop_end got done=%0d cnt=%0d exp 1 4", n_done - d0, pkt_sent_cnt);
        end
        d0 = n_done;
        start_run(0, 1, 0);
        repeat (3) step();
        n_chk++;
        if (busy !== 1'b0 || tx_valid !== 1'b0 || n_done !== d0) begin
            n_fail++; $display("FAIL zero_len got busy=%b valid=%b exp 0 0", busy, tx_valid);
        end
    endtask

    task automatic test_reset_mid_packet();
        int base; bit ok;
        ready_mode = 0;
        start_run(200, 1, 0);
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_chk++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 64'd0 || pkt_sent_cnt !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_clear got v=%b busy=%b exp 0 0", tx_valid, busy);
        end
        base = obs_q.size();
        build_exp(24, 1);
        start_run(24, 1, 0);
        wait_done(100, ok);
        n_chk++;
        if (!ok || obs_q.size() - base !== 3) begin
            n_fail++; $display("FAIL rstmid_nbeats got %0d ok=%b exp 3", obs_q.size() - base, ok);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (obs_q[base+i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rstmid_beat%0d got %h exp %h", i, obs_q[base+i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        int base; int gb; int len; int cnt; int ipg; int bad; bit ok;
        ready_mode = 1;
        for (int it = 0; it < 4; it++) begin
            len = $urandom_range(1, 300); cnt = $urandom_range(1, 3); ipg = $urandom_range(0, 3);
            base = obs_q.size(); gb = gap_q.size();
            build_exp(len, cnt);
            start_run(len, cnt, ipg);
            wait_done(2000, ok);
            n_chk++;
            if (!ok || obs_q.size() - base !== exp_q.size() || pkt_sent_cnt !== 32'(cnt)) begin
                n_fail++; $display("FAIL rand%0d_len got %0d beats cnt=%0d exp %0d beats cnt=%0d", it, obs_q.size() - base, pkt_sent_cnt, exp_q.size(), cnt);
            end
            bad = 0;
            for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++)
                if (obs_q[base+i] !== exp_q[i]) bad++;
            n_chk++;
            if (bad !== 0) begin
                n_fail++; $display("FAIL rand%0d_data got %0d wrong beats exp 0 (len=%0d)", it, bad, len);
            end
            bad = (gap_q.size() - gb !== cnt - 1) ? 1 : 0;
            for (int g = gb; g < gap_q.size(); g++)
                if (gap_q[g] !== ipg) bad++;
            n_chk++;
            if (bad !== 0) begin
                n_fail++; $display("FAIL rand%0d_gap got %0d bad gaps exp 0 (ipg=%0d)", it, bad, ipg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_short_eop();
        test_backpressure();
        test_gap();
        test_stop_continuous();
        test_reset_mid_packet();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
